// File: rtl/axi_mem_responder_if.sv
// axi_mem_responder_if
//   AXI4 bus bundle between a manager and the axi_mem_responder subordinate.
//   Parameters: axi_id_width_p, axi_addr_width_p, axi_data_width_p (64 only).
//   Channels:
//     AW : s_axi_awid/awaddr/awlen/awsize/awburst/awvalid -> , <- s_axi_awready
//     W  : s_axi_wdata/wstrb/wlast/wvalid -> , <- s_axi_wready
//     B  : <- s_axi_bid/bresp/bvalid , s_axi_bready ->
//     AR : s_axi_arid/araddr/arlen/arsize/arburst/arvalid -> , <- s_axi_arready
//     R  : <- s_axi_rid/rdata/rresp/rlast/rvalid , s_axi_rready ->
//   Modports: slave (the responder), master (the requesting side).
interface axi_mem_responder_if #(
  parameter int unsigned axi_id_width_p   = 4,
  parameter int unsigned axi_addr_width_p = 28,
  parameter int unsigned axi_data_width_p = 64
);
  logic [axi_id_width_p-1:0]     s_axi_awid;
  logic [axi_addr_width_p-1:0]   s_axi_awaddr;
  logic [7:0]                    s_axi_awlen;
  logic [2:0]                    s_axi_awsize;
  logic [1:0]                    s_axi_awburst;
  logic                          s_axi_awvalid;
  logic                          s_axi_awready;

  logic [axi_data_width_p-1:0]   s_axi_wdata;
  logic [axi_data_width_p/8-1:0] s_axi_wstrb;
  logic                          s_axi_wlast;
  logic                          s_axi_wvalid;
  logic                          s_axi_wready;

  logic [axi_id_width_p-1:0]     s_axi_bid;
  logic [1:0]                    s_axi_bresp;
  logic                          s_axi_bvalid;
  logic                          s_axi_bready;

  logic [axi_id_width_p-1:0]     s_axi_arid;
  logic [axi_addr_width_p-1:0]   s_axi_araddr;
  logic [7:0]                    s_axi_arlen;
  logic [2:0]                    s_axi_arsize;
  logic [1:0]                    s_axi_arburst;
  logic                          s_axi_arvalid;
  logic                          s_axi_arready;

  logic [axi_id_width_p-1:0]     s_axi_rid;
  logic [axi_data_width_p-1:0]   s_axi_rdata;
  logic [1:0]                    s_axi_rresp;
  logic                          s_axi_rlast;
  logic                          s_axi_rvalid;
  logic                          s_axi_rready;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );
endinterface

// File: rtl/axi_mem_responder.sv
// axi_mem_responder
//   AXI4 subordinate backed by a mem_els_p x 64-bit array, one transaction
//   outstanding at a time. Word address = byte address[3 +: log2(mem_els_p)],
//   bursts advance and wrap modulo mem_els_p. AW/AR arbitration alternates.
//   Ports:
//     clk_i   : single clock
//     reset_i : synchronous, active-high reset (array contents are kept)
//     s_axi   : axi_mem_responder_if.slave, all five AXI channels
//   Optional feature: define AXI_MEM_RESPONDER_ERR_CHECK_EN to flag
//   size != 8 bytes, burst != INCR and wlast misplacement with SLVERR.
//   Flagged writes leave the array untouched, flagged reads return zero data.
//   Without the macro every burst is INCR/8-byte and responses are OKAY.
module axi_mem_responder #(
  parameter int unsigned axi_id_width_p   = 4,
  parameter int unsigned axi_addr_width_p = 28,
  parameter int unsigned axi_data_width_p = 64,
  parameter int unsigned mem_els_p        = 1024
) (
  input logic                clk_i,
  input logic                reset_i,
  axi_mem_responder_if.slave s_axi
);
  localparam int unsigned lg_els_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
  localparam int unsigned bytes_lp  = axi_data_width_p / 8;

  typedef enum logic [1:0] {
    e_idle,
    e_write_data,
    e_write_resp,
    e_read_data
  } state_e;

  state_e                       r_state, w_state_next;
  logic                         r_prio_write;
  logic [axi_id_width_p-1:0]    r_id;
  logic [lg_els_lp-1:0]         r_addr;
  logic [7:0]                   r_len;
  logic [7:0]                   r_beat;
  logic                         r_err;
  logic [axi_data_width_p-1:0]  r_mem [mem_els_p];

  logic [axi_addr_width_p-1:0]  w_awaddr, w_araddr;
  logic                         w_awready, w_arready, w_wready, w_bvalid, w_rvalid;
  logic                         w_aw_hs, w_ar_hs, w_w_hs, w_r_hs, w_b_hs;
  logic                         w_last_beat;
  logic                         w_aw_err, w_ar_err, w_wlast_err;
  logic                         w_mem_we;
  logic [axi_data_width_p-1:0]  w_cur_word, w_merged;
  logic                         w_unused_ok;

  assign w_awaddr    = s_axi.s_axi_awaddr;
  assign w_araddr    = s_axi.s_axi_araddr;
  assign w_last_beat = (r_beat == r_len);
  assign w_cur_word  = r_mem[r_addr];

`ifdef AXI_MEM_RESPONDER_ERR_CHECK_EN
  assign w_aw_err    = (s_axi.s_axi_awsize != 3'd3) || (s_axi.s_axi_awburst != 2'b01);
  assign w_ar_err    = (s_axi.s_axi_arsize != 3'd3) || (s_axi.s_axi_arburst != 2'b01);
  assign w_wlast_err = (s_axi.s_axi_wlast != w_last_beat);
`else
  assign w_aw_err    = 1'b0;
  assign w_ar_err    = 1'b0;
  assign w_wlast_err = 1'b0;
`endif

  // Only the word-index bits of the addresses matter; the rest is ignored.
  assign w_unused_ok = ^{w_awaddr, w_araddr, s_axi.s_axi_awsize, s_axi.s_axi_awburst,
                         s_axi.s_axi_arsize, s_axi.s_axi_arburst, s_axi.s_axi_wlast};

  // Next state and ready/valid. Reset forces every handshake signal low
  // combinationally so nothing is accepted or offered during reset.
  always_comb begin
    w_state_next = r_state;
    w_awready    = 1'b0;
    w_arready    = 1'b0;
    w_wready     = 1'b0;
    w_bvalid     = 1'b0;
    w_rvalid     = 1'b0;
    if (!reset_i) begin
      unique case (r_state)
        e_idle: begin
          w_awready = ~s_axi.s_axi_arvalid | r_prio_write;
          w_arready = ~s_axi.s_axi_awvalid | ~r_prio_write;
          if (s_axi.s_axi_awvalid && w_awready)      w_state_next = e_write_data;
          else if (s_axi.s_axi_arvalid && w_arready) w_state_next = e_read_data;
        end
        e_write_data: begin
          w_wready = 1'b1;
          if (s_axi.s_axi_wvalid && w_last_beat) w_state_next = e_write_resp;
        end
        e_write_resp: begin
          w_bvalid = 1'b1;
          if (s_axi.s_axi_bready) w_state_next = e_idle;
        end
        e_read_data: begin
          w_rvalid = 1'b1;
          if (s_axi.s_axi_rready && w_last_beat) w_state_next = e_idle;
        end
        default: w_state_next = e_idle;
      endcase
    end
  end

  assign w_aw_hs = w_awready & s_axi.s_axi_awvalid;
  assign w_ar_hs = w_arready & s_axi.s_axi_arvalid;
  assign w_w_hs  = w_wready  & s_axi.s_axi_wvalid;
  assign w_b_hs  = w_bvalid  & s_axi.s_axi_bready;
  assign w_r_hs  = w_rvalid  & s_axi.s_axi_rready;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= e_idle;
      r_prio_write <= 1'b1;
      r_id         <= '0;
      r_addr       <= '0;
      r_len        <= '0;
      r_beat       <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_aw_hs || w_ar_hs) r_prio_write <= ~r_prio_write;
      if (w_aw_hs) begin
        r_id   <= s_axi.s_axi_awid;
        r_addr <= w_awaddr[3 +: lg_els_lp];
        r_len  <= s_axi.s_axi_awlen;
        r_beat <= '0;
        r_err  <= w_aw_err;
      end else if (w_ar_hs) begin
        r_id   <= s_axi.s_axi_arid;
        r_addr <= w_araddr[3 +: lg_els_lp];
        r_len  <= s_axi.s_axi_arlen;
        r_beat <= '0;
        r_err  <= w_ar_err;
      end else if (w_w_hs || w_r_hs) begin
        r_addr <= r_addr + 1'b1;
        r_beat <= r_beat + 8'd1;
        r_err  <= r_err | (w_w_hs & w_wlast_err);
      end
    end
  end

  // Byte-lane merge of the incoming beat into the current word.
  always_comb begin
    w_merged = w_cur_word;
    for (int unsigned i = 0; i < bytes_lp; i++) begin
      if (s_axi.s_axi_wstrb[i]) w_merged[8*i +: 8] = s_axi.s_axi_wdata[8*i +: 8];
    end
  end

  assign w_mem_we = w_w_hs & ~r_err & ~w_wlast_err;

  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[r_addr] <= w_merged;
  end

  assign s_axi.s_axi_awready = w_awready;
  assign s_axi.s_axi_arready = w_arready;
  assign s_axi.s_axi_wready  = w_wready;
  assign s_axi.s_axi_bvalid  = w_bvalid;
  assign s_axi.s_axi_bid     = r_id;
  assign s_axi.s_axi_bresp   = (w_bvalid && r_err) ? 2'b10 : 2'b00;
  assign s_axi.s_axi_rvalid  = w_rvalid;
  assign s_axi.s_axi_rid     = r_id;
  assign s_axi.s_axi_rlast   = w_rvalid & w_last_beat;
  assign s_axi.s_axi_rresp   = (w_rvalid && r_err) ? 2'b10 : 2'b00;
  assign s_axi.s_axi_rdata   = (w_rvalid && !r_err) ? w_cur_word : '0;
endmodule

// File: tb/tb_axi_mem_responder.sv
module tb_axi_mem_responder;
  localparam int unsigned MEM_ELS = 64;
`ifdef AXI_MEM_RESPONDER_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  axi_mem_responder_if #(
    .axi_id_width_p(4), .axi_addr_width_p(28), .axi_data_width_p(64)
  ) ifc ();

  axi_mem_responder #(
    .axi_id_width_p(4), .axi_addr_width_p(28), .axi_data_width_p(64), .mem_els_p(MEM_ELS)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .s_axi(ifc.slave)
  );

  int checks = 0;
  int failures = 0;

  logic [63:0] ref_mem [MEM_ELS];
  logic [63:0] wbuf [256];
  logic [7:0]  sbuf [256];
  logic [63:0] rbuf [256];

  typedef struct {
    int unsigned word;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] exp;
  } vec_t;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic int unsigned word_of(input logic [27:0] addr, input int unsigned beat);
    return ((int'(addr) >> 3) + beat) % MEM_ELS;
  endfunction

  // Entered just after a falling edge; returns just after a falling edge.
  task automatic axi_write(input logic [3:0] id, input logic [27:0] addr,
                           input int unsigned len, input logic [1:0] burst);
    int unsigned cyc;
    int unsigned w;
    logic exp_err;
    exp_err = ERR_EN && (burst != 2'b01);
    ifc.s_axi_awid = id; ifc.s_axi_awaddr = addr; ifc.s_axi_awlen = 8'(len);
    ifc.s_axi_awsize = 3'd3; ifc.s_axi_awburst = burst; ifc.s_axi_awvalid = 1'b1;
    cyc = 0; #1;
    while (!ifc.s_axi_awready && cyc < 50) begin @(negedge clk); #1; cyc++; end
    chk("aw_accept", ifc.s_axi_awready, 1'b1);
    @(posedge clk); @(negedge clk);
    ifc.s_axi_awvalid = 1'b0;
    for (int unsigned b = 0; b <= len; b++) begin
      ifc.s_axi_wdata = wbuf[b]; ifc.s_axi_wstrb = sbuf[b];
      ifc.s_axi_wlast = (b == len); ifc.s_axi_wvalid = 1'b1;
      cyc = 0; #1;
      while (!ifc.s_axi_wready && cyc < 50) begin @(negedge clk); #1; cyc++; end
      chk("w_accept", ifc.s_axi_wready, 1'b1);
      @(posedge clk); @(negedge clk);
    end
    ifc.s_axi_wvalid = 1'b0; ifc.s_axi_wlast = 1'b0;
    ifc.s_axi_bready = 1'b1;
    cyc = 0; #1;
    while (!ifc.s_axi_bvalid && cyc < 50) begin @(negedge clk); #1; cyc++; end
    chk("bvalid", ifc.s_axi_bvalid, 1'b1);
    chk("bid", ifc.s_axi_bid, id);
    chk("bresp", ifc.s_axi_bresp, exp_err ? 2'b10 : 2'b00);
    @(posedge clk); @(negedge clk);
    ifc.s_axi_bready = 1'b0;
    #1 chk("b_done", ifc.s_axi_bvalid, 1'b0);
    if (!exp_err) begin
      for (int unsigned b = 0; b <= len; b++) begin
        w = word_of(addr, b);
        for (int unsigned k = 0; k < 8; k++)
          if (sbuf[b][k]) ref_mem[w][8*k +: 8] = wbuf[b][8*k +: 8];
      end
    end
  endtask

  // stall=1 drives rready 1,0,1,0,... so every other cycle is a stall.
  task automatic axi_read(input logic [3:0] id, input logic [27:0] addr,
                          input int unsigned len, input logic [1:0] burst, input bit stall);
    int unsigned cyc;
    int unsigned b;
    logic exp_err;
    exp_err = ERR_EN && (burst != 2'b01);
    ifc.s_axi_arid = id; ifc.s_axi_araddr = addr; ifc.s_axi_arlen = 8'(len);
    ifc.s_axi_arsize = 3'd3; ifc.s_axi_arburst = burst; ifc.s_axi_arvalid = 1'b1;
    cyc = 0; #1;
    while (!ifc.s_axi_arready && cyc < 50) begin @(negedge clk); #1; cyc++; end
    chk("ar_accept", ifc.s_axi_arready, 1'b1);
    @(posedge clk); @(negedge clk);
    ifc.s_axi_arvalid = 1'b0;
    b = 0; cyc = 0;
    while (b <= len && cyc < 2 * (len + 1) + 20) begin
      ifc.s_axi_rready = stall ? (cyc % 2 == 0) : 1'b1;
      #1;
      chk("rvalid", ifc.s_axi_rvalid, 1'b1);
      chk("rdata", ifc.s_axi_rdata, exp_err ? 64'h0 : ref_mem[word_of(addr, b)]);
      chk("rlast", ifc.s_axi_rlast, b == len);
      chk("rid", ifc.s_axi_rid, id);
      chk("rresp", ifc.s_axi_rresp, exp_err ? 2'b10 : 2'b00);
      rbuf[b] = ifc.s_axi_rdata;
      @(posedge clk);
      if (ifc.s_axi_rready) b++;
      @(negedge clk);
      cyc++;
    end
    ifc.s_axi_rready = 1'b0;
    #1 chk("r_done", ifc.s_axi_rvalid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [5];
    logic [3:0]  rid;
    logic [27:0] raddr;
    int unsigned rlen;

    vecs[0] = '{word: 10, wdata: 64'hFFFF_FFFF_FFFF_FFFF, wstrb: 8'hFF, exp: 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[1] = '{word: 10, wdata: 64'h0,                   wstrb: 8'h0F, exp: 64'hFFFF_FFFF_0000_0000};
    vecs[2] = '{word: 10, wdata: 64'h1234_5678_9ABC_DEF0, wstrb: 8'h81, exp: 64'h12FF_FFFF_0000_00F0};
    vecs[3] = '{word: 11, wdata: 64'h0123_4567_89AB_CDEF, wstrb: 8'hFF, exp: 64'h0123_4567_89AB_CDEF};
    vecs[4] = '{word: 11, wdata: 64'hFFFF_FFFF_FFFF_FFFF, wstrb: 8'hF0, exp: 64'hFFFF_FFFF_89AB_CDEF};

    ifc.s_axi_awid = '0; ifc.s_axi_awaddr = '0; ifc.s_axi_awlen = '0; ifc.s_axi_awsize = '0;
    ifc.s_axi_awburst = '0; ifc.s_axi_awvalid = 1'b0;
    ifc.s_axi_wdata = '0; ifc.s_axi_wstrb = '0; ifc.s_axi_wlast = 1'b0; ifc.s_axi_wvalid = 1'b0;
    ifc.s_axi_bready = 1'b0;
    ifc.s_axi_arid = '0; ifc.s_axi_araddr = '0; ifc.s_axi_arlen = '0; ifc.s_axi_arsize = '0;
    ifc.s_axi_arburst = '0; ifc.s_axi_arvalid = 1'b0;
    ifc.s_axi_rready = 1'b0;
    for (int unsigned i = 0; i < MEM_ELS; i++) ref_mem[i] = '0;

    // Reset state
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_awready", ifc.s_axi_awready, 1'b0);
    chk("rst_wready",  ifc.s_axi_wready,  1'b0);
    chk("rst_bvalid",  ifc.s_axi_bvalid,  1'b0);
    chk("rst_arready", ifc.s_axi_arready, 1'b0);
    chk("rst_rvalid",  ifc.s_axi_rvalid,  1'b0);
    chk("rst_rlast",   ifc.s_axi_rlast,   1'b0);
    chk("rst_bresp",   ifc.s_axi_bresp,   2'b00);
    chk("rst_rresp",   ifc.s_axi_rresp,   2'b00);
    chk("rst_bid",     ifc.s_axi_bid,     4'h0);
    chk("rst_rid",     ifc.s_axi_rid,     4'h0);
    chk("rst_rdata",   ifc.s_axi_rdata,   64'h0);
    @(negedge clk);
    reset_i = 1'b0;

    // AW and AR together right after reset: write wins, read follows the B handshake
    ifc.s_axi_awid = 4'h1; ifc.s_axi_awaddr = 28'(5 * 8); ifc.s_axi_awlen = 8'd0;
    ifc.s_axi_awsize = 3'd3; ifc.s_axi_awburst = 2'b01; ifc.s_axi_awvalid = 1'b1;
    ifc.s_axi_arid = 4'h2; ifc.s_axi_araddr = 28'(5 * 8); ifc.s_axi_arlen = 8'd0;
    ifc.s_axi_arsize = 3'd3; ifc.s_axi_arburst = 2'b01; ifc.s_axi_arvalid = 1'b1;
    #1;
    chk("prio_awready", ifc.s_axi_awready, 1'b1);
    chk("prio_arready", ifc.s_axi_arready, 1'b0);
    wbuf[0] = 64'hDEAD_BEEF_0BAD_F00D; sbuf[0] = 8'hFF;
    axi_write(4'h1, 28'(5 * 8), 0, 2'b01);
    chk("ar_after_b", ifc.s_axi_arready, 1'b1);
    axi_read(4'h2, 28'(5 * 8), 0, 2'b01, 1'b0);
    chk("raw_data", rbuf[0], 64'hDEAD_BEEF_0BAD_F00D);

    // Fill the whole array with known content
    for (int unsigned i = 0; i < MEM_ELS; i++) begin
      wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF;
    end
    axi_write(4'h3, 28'h0, MEM_ELS - 1, 2'b01);

    // Four-beat write then read at 0x40
    wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
    for (int unsigned i = 0; i < 4; i++) sbuf[i] = 8'hFF;
    axi_write(4'h4, 28'h40, 3, 2'b01);
    axi_read(4'h5, 28'h40, 3, 2'b01, 1'b0);
    chk("burst4_b0", rbuf[0], 64'h11);
    chk("burst4_b1", rbuf[1], 64'h22);
    chk("burst4_b2", rbuf[2], 64'h33);
    chk("burst4_b3", rbuf[3], 64'h44);

    // Byte-strobe vectors
    for (int unsigned v = 0; v < 5; v++) begin
      wbuf[0] = vecs[v].wdata; sbuf[0] = vecs[v].wstrb;
      axi_write(4'h6, 28'(vecs[v].word * 8), 0, 2'b01);
      axi_read(4'h7, 28'(vecs[v].word * 8), 0, 2'b01, 1'b0);
      chk("strobe_vec", rbuf[0], vecs[v].exp);
    end

    // Eight-beat read with rready toggling
    axi_read(4'hA, 28'h100, 7, 2'b01, 1'b1);

    // Write straddling the top of the array wraps to word 0
    wbuf[0] = 64'hAAAA_0000_0000_0063; wbuf[1] = 64'hBBBB_0000_0000_0000; sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    axi_write(4'h8, 28'((MEM_ELS - 1) * 8), 1, 2'b01);
    axi_read(4'h9, 28'h0, 0, 2'b01, 1'b0);
    chk("wrap_word0", rbuf[0], 64'hBBBB_0000_0000_0000);
    axi_read(4'h9, 28'((MEM_ELS - 2) * 8), 3, 2'b01, 1'b0);
    chk("wrap_top", rbuf[1], 64'hAAAA_0000_0000_0063);

    // FIXED burst type: SLVERR with error checking, plain INCR otherwise
    wbuf[0] = 64'hCAFE_CAFE_CAFE_CAFE; sbuf[0] = 8'hFF;
    axi_write(4'hB, 28'(20 * 8), 0, 2'b00);
    axi_read(4'hC, 28'(20 * 8), 1, 2'b00, 1'b0);

    // Reset in the middle of a read burst
    ifc.s_axi_arid = 4'hD; ifc.s_axi_araddr = 28'h0; ifc.s_axi_arlen = 8'd7;
    ifc.s_axi_arsize = 3'd3; ifc.s_axi_arburst = 2'b01; ifc.s_axi_arvalid = 1'b1;
    #1 chk("mid_ar_accept", ifc.s_axi_arready, 1'b1);
    @(posedge clk); @(negedge clk);
    ifc.s_axi_arvalid = 1'b0; ifc.s_axi_rready = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    #1 chk("mid_rvalid_pre", ifc.s_axi_rvalid, 1'b1);
    reset_i = 1'b1;
    @(posedge clk); @(negedge clk);
    #1;
    chk("mid_rvalid", ifc.s_axi_rvalid, 1'b0);
    chk("mid_rlast",  ifc.s_axi_rlast,  1'b0);
    chk("mid_rdata",  ifc.s_axi_rdata,  64'h0);
    chk("mid_arready_rst", ifc.s_axi_arready, 1'b0);
    ifc.s_axi_rready = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("mid_arready", ifc.s_axi_arready, 1'b1);
    chk("mid_awready", ifc.s_axi_awready, 1'b1);
    axi_read(4'hE, 28'h0, 7, 2'b01, 1'b0);

    // Randomized traffic against the reference array
    for (int n = 0; n < 30; n++) begin
      rid = 4'($urandom);
      raddr = 28'($urandom);
      rlen = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        for (int unsigned b = 0; b <= rlen; b++) begin
          wbuf[b] = {$urandom, $urandom}; sbuf[b] = 8'($urandom);
        end
        axi_write(rid, raddr, rlen, 2'b01);
      end else begin
        axi_read(rid, raddr, rlen, 2'b01, 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
